// File: rtl/memval_collector.sv
`default_nettype none
// ============================================================================
//  Module   : memval_collector
//  Purpose  : Block-read consumer for the multiplier result memory. Requests
//             one block read, checks every returned word against coef*index
//             and reports pass/fail, error count, first failing index and an
//             idle timeout.
//  Revision : 1.0  initial release
// ============================================================================
module memval_collector #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255   // must be >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       coef,
    input  logic              RDY_mult,
    output logic              EN_blockRead,
    input  logic              VALID_memVal,
    input  logic [WIDTH-1:0]  memVal_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [ADDR_W:0]   word_count
);

    localparam int c_PROD_W = 16 + ADDR_W;
    localparam int c_TMR_W  = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    // The cycle of the last accepted word (or the request cycle) counts as
    // elapsed cycle 0, so the run closes exactly TIMEOUT cycles after it.
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT - 2);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [ADDR_W:0]    c_LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]    c_CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_REQ      = 3'd2,
        S_COLLECT  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [15:0]         r_coef;
    logic [ADDR_W:0]     r_errCount;
    logic [ADDR_W-1:0]   r_firstErrIdx;
    logic [ADDR_W:0]     r_wordCount;
    logic [c_TMR_W-1:0]  r_idleTmr;
    logic                r_pass;
    logic                r_timeout;
    logic                r_busy;
    logic                r_en;
    logic                r_done;

    logic [ADDR_W-1:0]   w_index;
    logic [c_PROD_W-1:0] w_product;
    logic [WIDTH-1:0]    w_expected;
    logic                w_mismatch;
    logic                w_lastWord;
    logic                w_expire;

    assign w_index    = r_wordCount[ADDR_W-1:0];
    assign w_product  = c_PROD_W'(r_coef) * c_PROD_W'(w_index);
    assign w_expected = WIDTH'(w_product);
    assign w_mismatch = (memVal_data != w_expected);
    assign w_lastWord = VALID_memVal && (r_wordCount == c_LAST_WORD);
    assign w_expire   = !VALID_memVal && (r_idleTmr == c_TMR_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; the DEPTH-th word and the idle expiry both close the run.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (start)    w_nextState = S_WAIT_RDY;
            S_WAIT_RDY: if (RDY_mult) w_nextState = S_REQ;
            S_REQ:                    w_nextState = S_COLLECT;
            S_COLLECT:  if (w_lastWord || w_expire) w_nextState = S_DONE;
            S_DONE:                   w_nextState = S_IDLE;
            default:                  w_nextState = S_IDLE;
        endcase
    end

    // Registered status outputs and result counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coef        <= '0;
            r_errCount    <= '0;
            r_firstErrIdx <= '0;
            r_wordCount   <= '0;
            r_idleTmr     <= '0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_en          <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // Flags are decoded from the next state so they line up with it.
            r_busy <= (w_nextState != S_IDLE);
            r_en   <= (w_nextState == S_REQ);
            r_done <= (w_nextState == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_coef        <= coef;
                        r_errCount    <= '0;
                        r_firstErrIdx <= '0;
                        r_wordCount   <= '0;
                        r_idleTmr     <= '0;
                        r_pass        <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (VALID_memVal) begin
                        if (w_mismatch) begin
                            r_errCount <= r_errCount + c_CNT_ONE;
                            if (r_errCount == '0) begin
                                r_firstErrIdx <= w_index;
                            end
                        end
                        r_wordCount <= r_wordCount + c_CNT_ONE;
                        r_idleTmr   <= '0;
                        // Final word: verdict must be valid in the DONE cycle.
                        if (w_lastWord) begin
                            r_pass <= (r_errCount == '0) && !w_mismatch;
                        end
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_idleTmr <= r_idleTmr + c_TMR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign EN_blockRead  = r_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign err_count     = r_errCount;
    assign first_err_idx = r_firstErrIdx;
    assign word_count    = r_wordCount;

endmodule
`default_nettype wire

// File: tb/tb_memval_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memval_collector
//  Purpose  : Self-checking bench for memval_collector. A timeline model
//             predicts every output per cycle from the stimulus schedule;
//             literal expectations pin the test-plan scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memval_collector;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 255;
    localparam int MAXOFF  = 512;
    localparam int BIG     = 32'h3fff_ffff;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       coef;
    logic              RDY_mult;
    logic              EN_blockRead;
    logic              VALID_memVal;
    logic [WIDTH-1:0]  memVal_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_idx;
    logic [ADDR_W:0]   word_count;

    memval_collector #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .coef          (coef),
        .RDY_mult      (RDY_mult),
        .EN_blockRead  (EN_blockRead),
        .VALID_memVal  (VALID_memVal),
        .memVal_data   (memVal_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nTests = 0;
    int nFail  = 0;

    // Stimulus schedule, indexed by offset from the first COLLECT cycle.
    bit          vArr [MAXOFF];
    logic [31:0] dArr [MAXOFF];
    // Model: outputs visible at each offset, and the run's final results.
    int wcAt [MAXOFF];
    int errAt [MAXOFF];
    int firstAt [MAXOFF];
    int doneOff;
    int mWc, mErr, mFirst;
    bit mPass, mTo;
    // Results held from the previous run.
    int pWc = 0, pErr = 0, pFirst = 0;
    bit pPass = 0, pTo = 0;
    // Current run timeline (BIG when no run is pending).
    int sCyc = BIG, rCyc = BIG, c0 = BIG, dCyc = BIG;
    int runS, runR, runC0;
    int doneSeen, enSeen, enCount;
    bit chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nTests++;
        if (act !== want) begin
            nFail++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word i at offset i*(gap+1); words errA/errB are corrupted by +1.
    task automatic fill_stream(input int coefV, input int nWords, input int gap,
                               input int errA, input int errB);
        for (int o = 0; o < MAXOFF; o++) begin
            vArr[o] = 1'b0;
            dArr[o] = '0;
        end
        for (int i = 0; i < nWords; i++) begin
            int o;
            o = i * (gap + 1);
            vArr[o] = 1'b1;
            dArr[o] = coefV * i + ((i == errA || i == errB) ? 1 : 0);
        end
    endtask

    // Walk the schedule: a run ends on the DEPTH-th word (results visible the
    // next cycle) or TIMEOUT cycles after the last word / the request cycle.
    task automatic model_run(input int coefV);
        int wc, err, first, last;
        logic [31:0] want;
        wc = 0; err = 0; first = 0; last = -1;
        doneOff = MAXOFF - 1;
        mTo = 1'b0;
        for (int off = 0; off < MAXOFF; off++) begin
            wcAt[off]    = wc;
            errAt[off]   = err;
            firstAt[off] = first;
            if (wc == DEPTH) begin
                doneOff = off;
                break;
            end
            if (off - last == TIMEOUT) begin
                doneOff = off;
                mTo = 1'b1;
                break;
            end
            if (vArr[off]) begin
                want = coefV * wc;
                if (dArr[off] != want) begin
                    if (err == 0) first = wc;
                    err++;
                end
                wc++;
                last = off;
            end
        end
        mWc = wc; mErr = err; mFirst = first;
        mPass = (err == 0) && (wc == DEPTH) && !mTo;
    endtask

    // Expected outputs for the current cycle from the run timeline.
    task automatic compare_now();
        int eWc, eErr, eFirst;
        bit eBusy, eEn, eDone, ePass, eTo;
        if (cyc <= sCyc) begin
            eBusy = 0; eEn = 0; eDone = 0;
            eWc = pWc; eErr = pErr; eFirst = pFirst; ePass = pPass; eTo = pTo;
        end else if (cyc <= dCyc) begin
            eBusy = 1;
            eEn   = (cyc == rCyc + 1);
            eDone = (cyc == dCyc);
            if (cyc < c0) begin
                eWc = 0; eErr = 0; eFirst = 0;
            end else begin
                eWc = wcAt[cyc - c0]; eErr = errAt[cyc - c0]; eFirst = firstAt[cyc - c0];
            end
            ePass = eDone ? mPass : 1'b0;
            eTo   = eDone ? mTo : 1'b0;
        end else begin
            eBusy = 0; eEn = 0; eDone = 0;
            eWc = mWc; eErr = mErr; eFirst = mFirst; ePass = mPass; eTo = mTo;
        end
        check("busy", busy, eBusy);
        check("EN_blockRead", EN_blockRead, eEn);
        check("done", done, eDone);
        check("pass", pass, ePass);
        check("timeout", timeout, eTo);
        check("word_count", word_count, eWc);
        check("err_count", err_count, eErr);
        check("first_err_idx", first_err_idx, eFirst);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk) compare_now();
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en"}, EN_blockRead, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_first"}, first_err_idx, 0);
        check({tag, "_wc"}, word_count, 0);
    endtask

    // One collection run; abortAt>0 pulses rst at COLLECT offset abortAt.
    task automatic do_run(input int coefV, input int rdyWait, input bit dupStart, input int abortAt);
        model_run(coefV);
        sCyc = cyc;
        rCyc = cyc + 1 + rdyWait;
        c0   = rCyc + 2;
        dCyc = c0 + doneOff;
        runS = sCyc; runR = rCyc; runC0 = c0;
        doneSeen = -1; enSeen = -1; enCount = 0;
        forever begin
            RDY_mult = (cyc >= rCyc) || (rdyWait == 0);
            start    = (cyc == sCyc) || (dupStart && (cyc == sCyc + 3 || cyc == dCyc));
            coef     = (cyc == sCyc) ? coefV[15:0] : 16'hBEEF;
            if (cyc >= c0 && cyc < dCyc) begin
                VALID_memVal = vArr[cyc - c0];
                memVal_data  = dArr[cyc - c0];
            end else if (cyc > sCyc && cyc <= dCyc) begin
                VALID_memVal = 1'b1;
                memVal_data  = $urandom;
            end else begin
                VALID_memVal = 1'b0;
                memVal_data  = '0;
            end
            if (abortAt > 0 && cyc == c0 + abortAt) begin
                check("abort_wc_before", word_count, abortAt);
                check("abort_err_before", err_count, mErr > 0 ? 1 : 0);
                chk = 0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                start = 1'b0;
                VALID_memVal = 1'b0;
                check_reset_values("abort");
                pWc = 0; pErr = 0; pFirst = 0; pPass = 0; pTo = 0;
                sCyc = BIG; rCyc = BIG; c0 = BIG; dCyc = BIG;
                chk = 1;
                return;
            end
            step();
            if (done && doneSeen < 0) doneSeen = cyc;
            if (EN_blockRead) begin
                enCount++;
                if (enSeen < 0) enSeen = cyc;
            end
            if (cyc > dCyc) break;
        end
        start = 1'b0;
        VALID_memVal = 1'b0;
        pWc = mWc; pErr = mErr; pFirst = mFirst; pPass = mPass; pTo = mTo;
        sCyc = BIG;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; coef = '0; RDY_mult = 1'b0;
        VALID_memVal = 1'b0; memVal_data = '0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_values("reset");
        chk = 1;
        repeat (2) step();

        // Nominal: coef=1, words 0..63 back to back.
        fill_stream(1, 64, 0, -1, -1);
        do_run(1, 0, 1'b0, 0);
        check("nom_en_pulses", enCount, 1);
        check("nom_en_latency", enSeen - runS, 2);
        check("nom_done_latency", doneSeen - (runC0 + 63), 1);
        check("nom_pass", pass, 1);
        check("nom_err", err_count, 0);
        check("nom_wc", word_count, 64);

        // Injected errors, started in the first IDLE cycle after done.
        fill_stream(3, 64, 0, 10, 40);
        do_run(3, 0, 1'b0, 0);
        check("inj_err", err_count, 2);
        check("inj_first", first_err_idx, 10);
        check("inj_pass", pass, 0);

        // Gapped stream: 3 idle cycles between words.
        repeat (2) step();
        fill_stream(7, 64, 3, -1, -1);
        do_run(7, 0, 1'b0, 0);
        check("gap_pass", pass, 1);
        check("gap_timeout", timeout, 0);
        check("gap_wc", word_count, 64);

        // Stall after 20 words.
        repeat (2) step();
        fill_stream(2, 20, 0, -1, -1);
        do_run(2, 0, 1'b0, 0);
        check("stall_done_gap", doneSeen - (runC0 + 19), 255);
        check("stall_timeout", timeout, 1);
        check("stall_wc", word_count, 20);
        check("stall_pass", pass, 0);

        // Ready gating with repeated start while busy.
        repeat (2) step();
        fill_stream(5, 64, 0, -1, -1);
        do_run(5, 10, 1'b1, 0);
        check("gate_en_pulses", enCount, 1);
        check("gate_en_after_rdy", enSeen - runR, 1);
        check("gate_pass", pass, 1);

        // Reset in the middle of COLLECT after 30 words.
        repeat (2) step();
        fill_stream(9, 64, 0, 3, -1);
        do_run(9, 0, 1'b0, 30);
        repeat (3) step();

        // Full run after the reset, widest coefficient.
        fill_stream(65535, 64, 0, -1, -1);
        do_run(65535, 0, 1'b0, 0);
        check("post_pass", pass, 1);
        check("post_wc", word_count, 64);
        repeat (3) step();

        chk = 0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
